// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, requests from the icache and feeds IF/ID.
// Handles stalls with a one-entry skid buffer, redirects (also behind a miss) and HALT.
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP = 6'b111111
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] imemaddr,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        ifid_en,
    output logic        flush_ifid,
    output logic [31:0] pcplus4_out,
    output logic [31:0] instr_out,
    output logic [31:0] next_pc_out,
    output logic        halted
);

    typedef enum logic [1:0] {FETCH, DRAIN, HALTED} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] buf_data, buf_data_n;
    logic        buf_valid, buf_valid_n;
    logic [31:0] target, target_n;
    logic [31:0] pc_plus4;
    logic [31:0] fetched;
    logic        ren, en, flush;

    assign pc_plus4 = pc + 32'd4;
    assign fetched  = buf_valid ? buf_data : imemload;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= FETCH;
            pc        <= PC_INIT;
            buf_data  <= 32'h0;
            buf_valid <= 1'b0;
            target    <= 32'h0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            buf_data  <= buf_data_n;
            buf_valid <= buf_valid_n;
            target    <= target_n;
        end
    end

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        buf_data_n  = buf_data;
        buf_valid_n = buf_valid;
        target_n    = target;
        ren         = 1'b0;
        en          = 1'b0;
        flush       = 1'b0;
        case (state)
            FETCH: begin
                ren = !buf_valid;
                if (redirect) begin
                    flush = 1'b1;
                    // A miss in flight keeps its address; the target waits in DRAIN.
                    if (ren && !ihit) begin
                        target_n = redirect_pc;
                        state_n  = DRAIN;
                    end else begin
                        pc_n        = redirect_pc;
                        buf_valid_n = 1'b0;
                    end
                end else if ((ihit || buf_valid) && !stall) begin
                    en          = 1'b1;
                    pc_n        = pc_plus4;
                    buf_valid_n = 1'b0;
                    if (fetched[31:26] == HALT_OP)
                        state_n = HALTED;
                end else if (ihit && stall && !buf_valid) begin
                    buf_data_n  = imemload;
                    buf_valid_n = 1'b1;
                end
            end
            DRAIN: begin
                ren   = 1'b1;
                flush = 1'b1;
                if (redirect && !ihit) begin
                    target_n = redirect_pc;
                end else if (redirect) begin
                    pc_n        = redirect_pc;
                    buf_valid_n = 1'b0;
                    state_n     = FETCH;
                end else if (ihit) begin
                    pc_n    = target;
                    state_n = FETCH;
                end
            end
            HALTED: begin
                if (redirect) begin
                    flush       = 1'b1;
                    pc_n        = redirect_pc;
                    buf_valid_n = 1'b0;
                    state_n     = FETCH;
                end
            end
            default: state_n = FETCH;
        endcase
    end

    // Control and data outputs stay quiet while reset is held.
    assign iREN        = ren & !RST;
    assign ifid_en     = en & !RST;
    assign flush_ifid  = flush & !RST;
    assign halted      = (state == HALTED);
    assign imemaddr    = pc;
    assign pcplus4_out = pc_plus4;
    assign next_pc_out = pc_plus4;
    assign instr_out   = RST ? 32'h0 : fetched;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, skid buffer, redirects, DRAIN, HALT, PC wrap.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst, rst2;
    logic        ihit, stall, redirect;
    logic [31:0] imemload, redirect_pc;

    logic        iren, ifid_en, flush, halted;
    logic [31:0] imemaddr, pcplus4, instr, next_pc;
    logic        iren_w, ifid_en_w, flush_w, halted_w;
    logic [31:0] imemaddr_w, pcplus4_w, instr_w, next_pc_w;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .CLK(clk), .RST(rst), .ihit(ihit), .imemload(imemload), .iREN(iren),
        .imemaddr(imemaddr), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .ifid_en(ifid_en), .flush_ifid(flush), .pcplus4_out(pcplus4), .instr_out(instr),
        .next_pc_out(next_pc), .halted(halted)
    );

    fetch_stage #(.PC_INIT(32'hFFFF_FFFC)) dut_wrap (
        .CLK(clk), .RST(rst2), .ihit(ihit), .imemload(imemload), .iREN(iren_w),
        .imemaddr(imemaddr_w), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .ifid_en(ifid_en_w), .flush_ifid(flush_w), .pcplus4_out(pcplus4_w), .instr_out(instr_w),
        .next_pc_out(next_pc_w), .halted(halted_w)
    );

    // Advance to just after the next rising edge, where inputs are changed.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; ihit = 1'b0; stall = 1'b0; redirect = 1'b0;
        redirect_pc = 32'h0; imemload = 32'h0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ihit = 1'b1; stall = 1'b0; redirect = 1'b0;
        redirect_pc = 32'h0; imemload = 32'hDEAD_BEEF;
        tick(); tick();
        #1;
        n_checks++; if (iren !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_iren: got %0b expected 0", iren); end
        n_checks++; if (ifid_en !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ifid_en: got %0b expected 0", ifid_en); end
        n_checks++; if (flush !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_flush: got %0b expected 0", flush); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_halted: got %0b expected 0", halted); end
        n_checks++; if (imemaddr !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_imemaddr: got %h expected 00000000", imemaddr); end
        n_checks++; if (instr !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_instr: got %h expected 00000000", instr); end
        n_checks++; if (pcplus4 !== 32'h4) begin n_fail++; $display("[TB] FAIL reset_pcplus4: got %h expected 00000004", pcplus4); end
        tick();
        rst = 1'b0; ihit = 1'b0;
        #1;
        n_checks++; if (iren !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_first_req: got %0b expected 1", iren); end
    endtask

    task automatic test_stream();
        logic [31:0] word;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            word = 32'h1000_0000 + k;
            ihit = 1'b1; imemload = word;
            #1;
            n_checks++; if (imemaddr !== 32'(4 * k)) begin n_fail++; $display("[TB] FAIL stream_addr%0d: got %h expected %h", k, imemaddr, 4 * k); end
            n_checks++; if (ifid_en !== 1'b1) begin n_fail++; $display("[TB] FAIL stream_en%0d: got %0b expected 1", k, ifid_en); end
            n_checks++; if (pcplus4 !== 32'(4 * k + 4)) begin n_fail++; $display("[TB] FAIL stream_pcplus4_%0d: got %h expected %h", k, pcplus4, 4 * k + 4); end
            n_checks++; if (next_pc !== 32'(4 * k + 4)) begin n_fail++; $display("[TB] FAIL stream_nextpc%0d: got %h expected %h", k, next_pc, 4 * k + 4); end
            n_checks++; if (instr !== word) begin n_fail++; $display("[TB] FAIL stream_instr%0d: got %h expected %h", k, instr, word); end
            tick();
        end
        ihit = 1'b0;
    endtask

    task automatic test_stall();
        do_reset();
        ihit = 1'b1; imemload = 32'h2000_0000;
        tick();
        imemload = 32'h2000_0004;
        tick();
        // First stall cycle: hit captured into the skid buffer.
        stall = 1'b1; imemload = 32'h2000_0008;
        #1;
        n_checks++; if (ifid_en !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_en0: got %0b expected 0", ifid_en); end
        n_checks++; if (imemaddr !== 32'h8) begin n_fail++; $display("[TB] FAIL stall_addr0: got %h expected 00000008", imemaddr); end
        tick();
        for (int c = 1; c < 3; c++) begin
            ihit = 1'b0; imemload = 32'hBAD0_0000;
            #1;
            n_checks++; if (iren !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_iren%0d: got %0b expected 0", c, iren); end
            n_checks++; if (ifid_en !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_en%0d: got %0b expected 0", c, ifid_en); end
            n_checks++; if (imemaddr !== 32'h8) begin n_fail++; $display("[TB] FAIL stall_addr%0d: got %h expected 00000008", c, imemaddr); end
            tick();
        end
        stall = 1'b0;
        #1;
        n_checks++; if (ifid_en !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_release_en: got %0b expected 1", ifid_en); end
        n_checks++; if (instr !== 32'h2000_0008) begin n_fail++; $display("[TB] FAIL stall_release_instr: got %h expected 20000008", instr); end
        n_checks++; if (pcplus4 !== 32'hC) begin n_fail++; $display("[TB] FAIL stall_release_pcplus4: got %h expected 0000000c", pcplus4); end
        tick();
        ihit = 1'b1; imemload = 32'h2000_000C;
        #1;
        n_checks++; if (iren !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_next_iren: got %0b expected 1", iren); end
        n_checks++; if (imemaddr !== 32'hC) begin n_fail++; $display("[TB] FAIL stall_next_addr: got %h expected 0000000c", imemaddr); end
        n_checks++; if (instr !== 32'h2000_000C) begin n_fail++; $display("[TB] FAIL stall_next_instr: got %h expected 2000000c", instr); end
        tick();
        ihit = 1'b0;
    endtask

    task automatic test_redirect_hit();
        do_reset();
        ihit = 1'b1; imemload = 32'h3000_0000; redirect = 1'b1; redirect_pc = 32'h100;
        #1;
        n_checks++; if (flush !== 1'b1) begin n_fail++; $display("[TB] FAIL redir_flush: got %0b expected 1", flush); end
        n_checks++; if (ifid_en !== 1'b0) begin n_fail++; $display("[TB] FAIL redir_en: got %0b expected 0", ifid_en); end
        tick();
        ihit = 1'b0; redirect = 1'b0;
        #1;
        n_checks++; if (imemaddr !== 32'h100) begin n_fail++; $display("[TB] FAIL redir_addr: got %h expected 00000100", imemaddr); end
        n_checks++; if (flush !== 1'b0) begin n_fail++; $display("[TB] FAIL redir_flush_after: got %0b expected 0", flush); end
        n_checks++; if (iren !== 1'b1) begin n_fail++; $display("[TB] FAIL redir_iren_after: got %0b expected 1", iren); end
    endtask

    task automatic test_drain();
        do_reset();
        ihit = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
        tick();
        ihit = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
        #1;
        n_checks++; if (flush !== 1'b1) begin n_fail++; $display("[TB] FAIL drain_flush0: got %0b expected 1", flush); end
        n_checks++; if (imemaddr !== 32'h40) begin n_fail++; $display("[TB] FAIL drain_addr0: got %h expected 00000040", imemaddr); end
        tick();
        redirect = 1'b0; redirect_pc = 32'h0;
        for (int c = 1; c < 4; c++) begin
            #1;
            n_checks++; if (imemaddr !== 32'h40) begin n_fail++; $display("[TB] FAIL drain_addr%0d: got %h expected 00000040", c, imemaddr); end
            n_checks++; if (flush !== 1'b1) begin n_fail++; $display("[TB] FAIL drain_flush%0d: got %0b expected 1", c, flush); end
            n_checks++; if (iren !== 1'b1) begin n_fail++; $display("[TB] FAIL drain_iren%0d: got %0b expected 1", c, iren); end
            tick();
        end
        ihit = 1'b1; imemload = 32'h4000_0040;
        #1;
        n_checks++; if (ifid_en !== 1'b0) begin n_fail++; $display("[TB] FAIL drain_hit_en: got %0b expected 0", ifid_en); end
        n_checks++; if (flush !== 1'b1) begin n_fail++; $display("[TB] FAIL drain_hit_flush: got %0b expected 1", flush); end
        tick();
        ihit = 1'b0;
        #1;
        n_checks++; if (imemaddr !== 32'h200) begin n_fail++; $display("[TB] FAIL drain_exit_addr: got %h expected 00000200", imemaddr); end
        n_checks++; if (flush !== 1'b0) begin n_fail++; $display("[TB] FAIL drain_exit_flush: got %0b expected 0", flush); end
    endtask

    task automatic test_halt();
        do_reset();
        ihit = 1'b1;
        for (int k = 0; k < 4; k++) begin
            imemload = 32'h1000_0000 + k;
            tick();
        end
        imemload = 32'hFC00_0000;
        #1;
        n_checks++; if (ifid_en !== 1'b1) begin n_fail++; $display("[TB] FAIL halt_deliver_en: got %0b expected 1", ifid_en); end
        n_checks++; if (instr !== 32'hFC00_0000) begin n_fail++; $display("[TB] FAIL halt_deliver_instr: got %h expected fc000000", instr); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("[TB] FAIL halt_early: got %0b expected 0", halted); end
        tick();
        imemload = 32'h1000_0014;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++; if (halted !== 1'b1) begin n_fail++; $display("[TB] FAIL halt_halted%0d: got %0b expected 1", c, halted); end
            n_checks++; if (iren !== 1'b0) begin n_fail++; $display("[TB] FAIL halt_iren%0d: got %0b expected 0", c, iren); end
            n_checks++; if (ifid_en !== 1'b0) begin n_fail++; $display("[TB] FAIL halt_en%0d: got %0b expected 0", c, ifid_en); end
            n_checks++; if (imemaddr !== 32'h14) begin n_fail++; $display("[TB] FAIL halt_pc%0d: got %h expected 00000014", c, imemaddr); end
            tick();
        end
        ihit = 1'b0; redirect = 1'b1; redirect_pc = 32'h80;
        #1;
        n_checks++; if (flush !== 1'b1) begin n_fail++; $display("[TB] FAIL halt_redir_flush: got %0b expected 1", flush); end
        tick();
        redirect = 1'b0;
        #1;
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("[TB] FAIL halt_resume_halted: got %0b expected 0", halted); end
        n_checks++; if (iren !== 1'b1) begin n_fail++; $display("[TB] FAIL halt_resume_iren: got %0b expected 1", iren); end
        n_checks++; if (imemaddr !== 32'h80) begin n_fail++; $display("[TB] FAIL halt_resume_addr: got %h expected 00000080", imemaddr); end
    endtask

    task automatic test_wrap_and_reset_drain();
        ihit = 1'b0; stall = 1'b0; redirect = 1'b0; imemload = 32'h5000_0000;
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0; ihit = 1'b1;
        #1;
        n_checks++; if (imemaddr_w !== 32'hFFFF_FFFC) begin n_fail++; $display("[TB] FAIL wrap_addr: got %h expected fffffffc", imemaddr_w); end
        n_checks++; if (pcplus4_w !== 32'h0) begin n_fail++; $display("[TB] FAIL wrap_pcplus4: got %h expected 00000000", pcplus4_w); end
        n_checks++; if (ifid_en_w !== 1'b1) begin n_fail++; $display("[TB] FAIL wrap_en: got %0b expected 1", ifid_en_w); end
        tick();
        ihit = 1'b0;
        #1;
        n_checks++; if (imemaddr_w !== 32'h0) begin n_fail++; $display("[TB] FAIL wrap_next_addr: got %h expected 00000000", imemaddr_w); end
        redirect = 1'b1; redirect_pc = 32'h300;
        tick();
        redirect = 1'b0;
        #1;
        n_checks++; if (flush_w !== 1'b1) begin n_fail++; $display("[TB] FAIL rstdrain_in_drain: got %0b expected 1", flush_w); end
        rst2 = 1'b1;
        #1;
        n_checks++; if (iren_w !== 1'b0) begin n_fail++; $display("[TB] FAIL rstdrain_iren: got %0b expected 0", iren_w); end
        n_checks++; if (flush_w !== 1'b0) begin n_fail++; $display("[TB] FAIL rstdrain_flush: got %0b expected 0", flush_w); end
        n_checks++; if (imemaddr_w !== 32'hFFFF_FFFC) begin n_fail++; $display("[TB] FAIL rstdrain_pc: got %h expected fffffffc", imemaddr_w); end
        tick();
        #1;
        n_checks++; if (iren_w !== 1'b0) begin n_fail++; $display("[TB] FAIL rstdrain_iren_held: got %0b expected 0", iren_w); end
        rst2 = 1'b0;
        #1;
        n_checks++; if (iren_w !== 1'b1) begin n_fail++; $display("[TB] FAIL rstdrain_release_iren: got %0b expected 1", iren_w); end
        n_checks++; if (flush_w !== 1'b0) begin n_fail++; $display("[TB] FAIL rstdrain_release_flush: got %0b expected 0", flush_w); end
        n_checks++; if (imemaddr_w !== 32'hFFFF_FFFC) begin n_fail++; $display("[TB] FAIL rstdrain_release_pc: got %h expected fffffffc", imemaddr_w); end
        tick();
    endtask

    initial begin
        rst2 = 1'b1;
        $display("[TB] starting fetch_stage bench");
        test_reset();
        test_stream();
        test_stall();
        test_redirect_hit();
        test_drain();
        test_halt();
        test_wrap_and_reset_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
